// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL supervisor, the PLL wrapper and the reset tree.
// The master side is the supervisor itself.
interface pll_lock_supervisor_if #(
    parameter int N_RST = 3,
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             force_relock;
    logic             pll_reset;
    logic [N_RST-1:0] rst_out;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] loss_cnt;
    logic [CNT_W-1:0] retry_cnt;

    modport master (
        input  pll_lock, force_relock,
        output pll_reset, rst_out, ready, state, loss_cnt, retry_cnt
    );

    modport slave (
        output pll_lock, force_relock,
        input  pll_reset, rst_out, ready, state, loss_cnt, retry_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: holds the PLL in reset, filters its lock flag,
// retries on timeout and releases staged domain resets in ascending order.
module pll_lock_supervisor #(
    parameter int N_RST        = 3,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_FILT    = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGE_GAP    = 64,
    parameter int CNT_W        = 8
) (
    input  logic                   clkin,
    input  logic                   reset,
    pll_lock_supervisor_if.master  bus
);

    localparam int HOLD_W = $clog2(PLL_RST_CYC + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STG_N  = STAGE_GAP * N_RST;
    localparam int STG_W  = $clog2(STG_N + 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           cur_st, nxt_st;
    logic             lock_m, lock_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [FILT_W-1:0] filt_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [STG_W-1:0]  stg_cnt;
    logic             pll_reset_q, ready_q;
    logic [N_RST-1:0] rst_q, rst_nxt;
    logic [CNT_W-1:0] loss_q, retry_q;
    logic             loss_evt, retry_evt;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
        end
    end

    // Relock request outranks both lock acceptance and lock loss.
    always_comb begin
        nxt_st    = cur_st;
        loss_evt  = 1'b0;
        retry_evt = 1'b0;
        case (cur_st)
            ST_PLL_RST: begin
                if (hold_cnt == HOLD_W'(PLL_RST_CYC - 1))
                    nxt_st = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (bus.force_relock)
                    nxt_st = ST_PLL_RST;
                else if (lock_s && filt_cnt == FILT_W'(LOCK_FILT - 1))
                    nxt_st = ST_RELEASE;
                else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    nxt_st    = ST_PLL_RST;
                    retry_evt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (bus.force_relock)
                    nxt_st = ST_PLL_RST;
                else if (!lock_s) begin
                    nxt_st   = ST_PLL_RST;
                    loss_evt = 1'b1;
                end else if (stg_cnt == STG_W'(STG_N))
                    nxt_st = ST_RUN;
            end
            ST_RUN: begin
                if (bus.force_relock)
                    nxt_st = ST_PLL_RST;
                else if (!lock_s) begin
                    nxt_st   = ST_PLL_RST;
                    loss_evt = 1'b1;
                end
            end
            default: nxt_st = ST_PLL_RST;
        endcase
    end

    always_comb begin
        rst_nxt = '1;
        if (nxt_st == ST_RUN)
            rst_nxt = '0;
        else if (cur_st == ST_RELEASE && nxt_st == ST_RELEASE) begin
            for (int unsigned i = 0; i < N_RST; i++)
                rst_nxt[i] = (32'(stg_cnt) + 32'd1) < (32'(STAGE_GAP) * (i + 32'd1));
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset)
            cur_st <= ST_PLL_RST;
        else
            cur_st <= nxt_st;
    end

    // Any state change, including re-entry to PLL_RST, restarts every phase counter.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            filt_cnt <= '0;
            tmo_cnt  <= '0;
            stg_cnt  <= '0;
        end else if (nxt_st != cur_st) begin
            hold_cnt <= '0;
            filt_cnt <= '0;
            tmo_cnt  <= '0;
            stg_cnt  <= '0;
        end else begin
            case (cur_st)
                ST_PLL_RST: hold_cnt <= hold_cnt + 1'b1;
                ST_WAIT_LOCK: begin
                    tmo_cnt  <= tmo_cnt + 1'b1;
                    filt_cnt <= lock_s ? filt_cnt + 1'b1 : '0;
                end
                ST_RELEASE: stg_cnt <= stg_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pll_reset_q <= 1'b1;
            rst_q       <= '1;
            ready_q     <= 1'b0;
            loss_q      <= '0;
            retry_q     <= '0;
        end else begin
            pll_reset_q <= (nxt_st == ST_PLL_RST);
            rst_q       <= rst_nxt;
            ready_q     <= (nxt_st == ST_RUN);
            if (loss_evt && loss_q != '1)
                loss_q <= loss_q + 1'b1;
            if (retry_evt && retry_q != '1)
                retry_q <= retry_q + 1'b1;
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.rst_out   = rst_q;
    assign bus.ready     = ready_q;
    assign bus.state     = cur_st;
    assign bus.loss_cnt  = loss_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed bring-up/loss/timeout scenarios plus
// randomized lock/relock traffic, all checked against a phase-level model.
module tb_pll_lock_supervisor;

    localparam int N_RST        = 3;
    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_FILT    = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int STAGE_GAP    = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clkin;
    logic reset;

    pll_lock_supervisor_if #(.N_RST(N_RST), .CNT_W(CNT_W)) bus ();

    pll_lock_supervisor #(
        .N_RST       (N_RST),
        .PLL_RST_CYC (PLL_RST_CYC),
        .LOCK_FILT   (LOCK_FILT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGE_GAP   (STAGE_GAP),
        .CNT_W       (CNT_W)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: phase, cycles completed in the phase, run of synced highs.
    int m_phase, m_age, m_run, m_loss, m_retry;
    bit m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_run = 0; m_loss = 0; m_retry = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic enter(input int p);
        m_phase = p; m_age = 0; m_run = 0;
    endtask

    task automatic model_step();
        bit ls, frc;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.pll_lock;
        frc  = bus.force_relock;
        case (m_phase)
            0: begin
                m_age++;
                if (m_age == PLL_RST_CYC) enter(1);
            end
            1: begin
                if (frc) enter(0);
                else begin
                    m_age++;
                    m_run = ls ? m_run + 1 : 0;
                    if (m_run == LOCK_FILT) enter(2);
                    else if (m_age == LOCK_TIMEOUT) begin
                        if (m_retry < CNT_MAX) m_retry++;
                        enter(0);
                    end
                end
            end
            2: begin
                if (frc) enter(0);
                else if (!ls) begin
                    if (m_loss < CNT_MAX) m_loss++;
                    enter(0);
                end else begin
                    m_age++;
                    if (m_age == STAGE_GAP * N_RST + 1) enter(3);
                end
            end
            default: begin
                if (frc) enter(0);
                else if (!ls) begin
                    if (m_loss < CNT_MAX) m_loss++;
                    enter(0);
                end
            end
        endcase
    endtask

    function automatic logic [N_RST-1:0] exp_rst();
        logic [N_RST-1:0] r;
        r = '1;
        if (m_phase == 3) r = '0;
        else if (m_phase == 2)
            for (int i = 0; i < N_RST; i++) r[i] = (m_age < STAGE_GAP * (i + 1));
        return r;
    endfunction

    task automatic compare_all();
        chk("state",     32'(bus.state),     32'(m_phase));
        chk("pll_reset", 32'(bus.pll_reset), 32'(m_phase == 0));
        chk("rst_out",   32'(bus.rst_out),   32'(exp_rst()));
        chk("ready",     32'(bus.ready),     32'(m_phase == 3));
        chk("loss_cnt",  32'(bus.loss_cnt),  32'(m_loss));
        chk("retry_cnt", 32'(bus.retry_cnt), 32'(m_retry));
    endtask

    task automatic tick();
        @(posedge clkin);
        if (reset) model_reset();
        else model_step();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(bus.state) != target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.state), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int pr_cnt, t_rel, t1, t2, n;
        reset = 1'b1;
        bus.pll_lock = 1'b0;
        bus.force_relock = 1'b0;
        model_reset();
        #2;
        compare_all();
        repeat (3) tick();
        reset = 1'b0;

        // Clean bring-up: lock rises 10 cycles after reset release
        pr_cnt = bus.pll_reset ? 1 : 0;
        repeat (10) begin
            tick();
            if (bus.pll_reset) pr_cnt++;
        end
        chk("pll_reset_hold_cycles", 32'(pr_cnt), 32'd4);
        bus.pll_lock = 1'b1;
        wait_state(2, 100, "reach_release");
        t_rel = cyc;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3)  chk("stage0_release", 32'(bus.rst_out), 32'b110);
            if (k == 6)  chk("stage1_release", 32'(bus.rst_out), 32'b100);
            if (k == 9)  chk("stage2_release", 32'(bus.rst_out), 32'b000);
            if (k == 9)  chk("ready_not_yet",  32'(bus.ready),   32'd0);
            if (k == 10) chk("ready_after_release", 32'(bus.ready), 32'd1);
        end
        chk("release_to_ready_cycles", 32'(cyc - t_rel), 32'd10);

        // Lock loss in RUN: two sync cycles plus one
        bus.pll_lock = 1'b0;
        tick(); tick();
        chk("loss_not_yet", 32'(bus.state), 32'd3);
        tick();
        chk("loss_state", 32'(bus.state), 32'd0);
        chk("loss_rst_out", 32'(bus.rst_out), 32'b111);
        chk("loss_cnt_one", 32'(bus.loss_cnt), 32'd1);
        bus.pll_lock = 1'b1;
        wait_state(3, 200, "relock_run");

        // force_relock coincident with lock loss in RUN
        bus.pll_lock = 1'b0;
        tick(); tick();
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        chk("force_loss_state", 32'(bus.state), 32'd0);
        chk("force_loss_cnt_unchanged", 32'(bus.loss_cnt), 32'd1);

        // force_relock during PLL_RST is ignored
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;

        // Lock glitch in WAIT_LOCK
        wait_state(1, 20, "glitch_wait_lock");
        bus.pll_lock = 1'b1;
        repeat (5) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        n = 0;
        while (bus.state != 2'd2 && n < 40) begin
            tick();
            n++;
        end
        chk("glitch_relock_ticks", 32'(n), 32'd10);
        wait_state(3, 40, "glitch_run");

        // Async reset during RELEASE when rst_out=100
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        wait_state(2, 100, "async_reach_release");
        n = 0;
        while (bus.rst_out != 3'b100 && n < 20) begin
            tick();
            n++;
        end
        chk("async_pre_rst_out", 32'(bus.rst_out), 32'b100);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_out", 32'(bus.rst_out), 32'b111);
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_loss_cnt", 32'(bus.loss_cnt), 32'd0);
        compare_all();
        tick(); tick();
        reset = 1'b0;

        // Timeout retries: lock held low
        bus.pll_lock = 1'b0;
        wait_state(1, 20, "tmo_wait_lock0");
        wait_state(0, 100, "tmo_first");
        t1 = cyc;
        wait_state(1, 20, "tmo_wait_lock1");
        wait_state(0, 100, "tmo_second");
        t2 = cyc;
        chk("timeout_period", 32'(t2 - t1), 32'd68);
        for (int r = 0; r < 16; r++) begin
            wait_state(1, 20, "tmo_loop_wait");
            wait_state(0, 100, "tmo_loop_rst");
        end
        chk("retry_saturated", 32'(bus.retry_cnt), 32'd15);

        // Randomized lock/relock traffic
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            bus.pll_lock = ($urandom_range(0, 3) != 0);
            len = bus.pll_lock ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 12));
            for (int t = 0; t < len; t++) begin
                bus.force_relock = ($urandom_range(0, 63) == 0);
                tick();
            end
            bus.force_relock = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
